fitness_kernel_prod_max_reduce: RTL and testbench
=================================================

FITNESS_KERNEL_PROD_MAX_REDUCE -- requirements
Module: fitness_kernel_prod_max_reduce

Interface
REQ-001 SHALL have parameter PROD_WIDTH, default 129, meaning width of the incoming unsigned product word.
REQ-002 SHALL have parameter SHIFT, default 64, meaning right-shift applied to each product (fixed-point scale removal).
REQ-003 SHALL have parameter OUT_WIDTH, default 64, meaning width of the scaled value and of the fitness result.
REQ-004 SHALL have parameter NDIM_WIDTH, default 8, meaning width of the dimension-count input.
REQ-005 SHALL have port ap_clk  input  1  sole clock, all logic rising-edge.
REQ-006 SHALL have port ap_rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port start  input  1  one-cycle request to begin a reduction; sampled only in IDLE.
REQ-008 SHALL have port ndim  input  NDIM_WIDTH  number of products to reduce; latched when start is accepted.
REQ-009 SHALL have port in_prod  input  PROD_WIDTH  unsigned product from the upstream multiplier.
REQ-010 SHALL have port in_valid  input  1  in_prod valid.
REQ-011 SHALL have port in_ready  output  1  block accepts in_prod this cycle.
REQ-012 SHALL have port out_fitness  output  OUT_WIDTH  maximum scaled product of the reduction.
REQ-013 SHALL have port out_valid  output  1  out_fitness valid.
REQ-014 SHALL have port out_ready  input  1  downstream accepts out_fitness.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port ovf  output  1  at least one product saturated in the current result; valid with out_valid.

Function
REQ-017 SHALL implement FSM states IDLE, ACCUM, OUTPUT.
REQ-018 IDLE: start=1 with ndim>0 SHALL latch ndim into a remaining-count register, clear max register to 0 and ovf to 0, and move to ACCUM.
REQ-019 IDLE: start=1 with ndim=0 SHALL clear max and ovf and move directly to OUTPUT (result 0, out_valid on the next cycle).
REQ-020 start SHALL be ignored outside IDLE; ndim SHALL be ignored except when start is accepted.
REQ-021 in_ready SHALL equal 1 exactly when state is ACCUM; a product is accepted only on a cycle with in_valid=1 and in_ready=1.
REQ-022 Scaled value SHALL be in_prod >> SHIFT; if any bit of in_prod at position >= SHIFT+OUT_WIDTH is 1, scaled value SHALL saturate to all ones and ovf SHALL set (sticky until next start).
REQ-023 On each accepted product, max SHALL update to the larger of max and the scaled value (unsigned compare), and the remaining count SHALL decrement by 1.
REQ-024 The accept that drives the remaining count from 1 to 0 SHALL move the FSM to OUTPUT; out_valid SHALL assert on the cycle immediately after that accept (latency 1).
REQ-025 OUTPUT: out_valid=1, out_fitness=max, ovf held; both SHALL remain stable until out_ready=1.
REQ-026 OUTPUT with out_ready=1 SHALL return to IDLE the next cycle with out_valid=0; a start in that same cycle SHALL be ignored.
REQ-027 in_valid idle cycles in ACCUM SHALL stall without changing max or count; no timeout.
REQ-028 Equal scaled values SHALL leave max unchanged; a scaled value of 0 is legal.

Reset
REQ-029 ap_rst=1 at any clock edge, including mid-ACCUM or OUTPUT, SHALL force IDLE, and out_fitness=0, out_valid=0, in_ready=0, busy=0, ovf=0, count=0 on the following cycle.
REQ-030 Products presented while ap_rst=1 SHALL be discarded; the first reduction after reset SHALL require a new start.

Verification
REQ-031 Basic: start, ndim=3; products 5*2^64+123, 9*2^64, 2*2^64+(2^64-1) -> out_fitness=9, ovf=0, out_valid 1 cycle after third accept.
REQ-032 Saturation: ndim=2; products 2^128, 7*2^64 -> out_fitness=0xFFFFFFFFFFFFFFFF, ovf=1.
REQ-033 Zero dims: start, ndim=0 -> out_valid=1 next cycle, out_fitness=0, in_ready never asserted.
REQ-034 Backpressure: ndim=1, product 3*2^64, out_ready low 4 cycles -> out_valid and out_fitness=3 held 4 cycles, IDLE one cycle after out_ready=1; start during OUTPUT ignored.
REQ-035 Input stall: ndim=2, in_valid gaps of 3 cycles between products 4*2^64 and 4*2^64 -> out_fitness=4, count decrements only on handshakes.
REQ-036 Reset mid-op: ndim=4, reset after 2 accepts -> all outputs 0 next cycle; new start ndim=1, product 1*2^64 -> out_fitness=1, ovf=0.

Source files
------------

// File: rtl/fitness_kernel_prod_max_reduce.sv
// Max-reduction of scaled unsigned products: each accepted product is shifted
// down by SHIFT, saturated to OUT_WIDTH bits, and folded into a running maximum.
module fitness_kernel_prod_max_reduce #(
  parameter int PROD_WIDTH = 129,
  parameter int SHIFT      = 64,
  parameter int OUT_WIDTH  = 64,
  parameter int NDIM_WIDTH = 8
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [NDIM_WIDTH-1:0] ndim,
  input  logic [PROD_WIDTH-1:0] in_prod,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [OUT_WIDTH-1:0]  out_fitness,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam int HI_LSB = SHIFT + OUT_WIDTH;

  state_t                r_state;
  logic [NDIM_WIDTH-1:0] r_count;
  logic [OUT_WIDTH-1:0]  r_max;
  logic                  r_ovf;

  logic                  w_sat;
  logic [OUT_WIDTH-1:0]  w_scaled;
  logic                  w_accept;

  // Any set bit above the representable window forces saturation.
  generate
    if (HI_LSB < PROD_WIDTH) begin : g_sat
      assign w_sat = |in_prod[PROD_WIDTH-1:HI_LSB];
    end else begin : g_no_sat
      assign w_sat = 1'b0;
    end
  endgenerate

  assign w_scaled = w_sat ? {OUT_WIDTH{1'b1}} : OUT_WIDTH'(in_prod >> SHIFT);
  assign w_accept = (r_state == ACCUM) && in_valid;

  assign in_ready    = (r_state == ACCUM);
  assign out_valid   = (r_state == OUTPUT);
  assign busy        = (r_state != IDLE);
  assign out_fitness = r_max;
  assign ovf         = r_ovf;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state <= IDLE;
      r_count <= '0;
      r_max   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_count <= ndim;
            r_max   <= '0;
            r_ovf   <= 1'b0;
            r_state <= (ndim == '0) ? OUTPUT : ACCUM;
          end
        end
        ACCUM: begin
          if (w_accept) begin
            if (w_scaled > r_max) r_max <= w_scaled;
            if (w_sat) r_ovf <= 1'b1;
            r_count <= r_count - 1'b1;
            if (r_count == NDIM_WIDTH'(1)) r_state <= OUTPUT;
          end
        end
        OUTPUT: begin
          // Result and ovf stay frozen until the downstream handshake.
          if (out_ready) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fitness_kernel_prod_max_reduce.sv
// Directed bench for fitness_kernel_prod_max_reduce: a table of reductions plus
// hand sequences for zero-length, backpressure, input stall and mid-op reset.
module tb_fitness_kernel_prod_max_reduce;

  localparam int PW = 129;
  localparam int OW = 64;
  localparam int NW = 8;

  logic          ap_clk = 1'b0;
  logic          ap_rst;
  logic          start;
  logic [NW-1:0] ndim;
  logic [PW-1:0] in_prod;
  logic          in_valid;
  logic          in_ready;
  logic [OW-1:0] out_fitness;
  logic          out_valid;
  logic          out_ready;
  logic          busy;
  logic          ovf;

  int checks = 0;
  int errors = 0;

  always #5 ap_clk = ~ap_clk;

  fitness_kernel_prod_max_reduce #(
    .PROD_WIDTH(PW), .SHIFT(64), .OUT_WIDTH(OW), .NDIM_WIDTH(NW)
  ) dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .start(start), .ndim(ndim),
    .in_prod(in_prod), .in_valid(in_valid), .in_ready(in_ready),
    .out_fitness(out_fitness), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .ovf(ovf)
  );

  typedef struct {
    string         name;
    int            n;
    logic [PW-1:0] prod [4];
    logic [OW-1:0] exp_fit;
    logic          exp_ovf;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [OW-1:0] act,
                       input logic [OW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ap_clk);
    #1;
  endtask

  function automatic logic [PW-1:0] p(input logic [63:0] hi, input logic [63:0] lo);
    logic [PW-1:0] v;
    v = (PW'(hi) << 64) | PW'(lo);
    return v;
  endfunction

  task automatic do_start(input int n);
    start = 1'b1;
    ndim  = NW'(n);
    tick();
    start = 1'b0;
    ndim  = NW'($urandom_range(1, 200));
  endtask

  // Present one product and wait (bounded) for its handshake.
  task automatic send(input string name, input logic [PW-1:0] v);
    int waited;
    waited = 0;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    if (!in_ready) check({name, " in_ready timeout"}, 64'(in_ready), 64'd1);
    in_prod  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_prod  = '1;
  endtask

  task automatic release_out(input string name);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, " out_valid after ack"}, 64'(out_valid), 64'd0);
    check({name, " busy after ack"}, 64'(busy), 64'd0);
  endtask

  initial begin
    logic [PW-1:0] big;
    big = '0;
    big[128] = 1'b1;

    vecs[0] = '{"basic", 3, '{p(5, 123), p(9, 0), p(2, 64'hFFFF_FFFF_FFFF_FFFF), '0},
                64'd9, 1'b0};
    vecs[1] = '{"saturate", 2, '{big, p(7, 0), '0, '0},
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[2] = '{"ovf_cleared", 2, '{p(1, 0), p(3, 7), '0, '0}, 64'd3, 1'b0};
    vecs[3] = '{"equal_vals", 3, '{p(6, 0), p(6, 5), p(2, 0), '0}, 64'd6, 1'b0};
    vecs[4] = '{"zero_scaled", 1, '{p(0, 64'hFFFF_FFFF_FFFF_FFFF), '0, '0, '0},
                64'd0, 1'b0};
    vecs[5] = '{"top_no_sat", 4, '{p(2, 0), p(64'hFFFF_FFFF_FFFF_FFFF, 9),
                p(64'h8000_0000_0000_0000, 0), p(0, 0)},
                64'hFFFF_FFFF_FFFF_FFFF, 1'b0};

    ap_rst = 1'b1; start = 1'b0; ndim = '0; in_prod = '1;
    in_valid = 1'b1; out_ready = 1'b0;
    repeat (3) tick();
    ap_rst = 1'b0;
    in_valid = 1'b0;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset ovf", 64'(ovf), 64'd0);
    check("reset fitness", out_fitness, 64'd0);

    for (int i = 0; i < 6; i++) begin
      do_start(vecs[i].n);
      check({vecs[i].name, " busy"}, 64'(busy), 64'd1);
      for (int k = 0; k < vecs[i].n; k++) begin
        send(vecs[i].name, vecs[i].prod[k]);
        if (k < vecs[i].n - 1)
          check({vecs[i].name, " early out_valid"}, 64'(out_valid), 64'd0);
      end
      check({vecs[i].name, " out_valid latency"}, 64'(out_valid), 64'd1);
      check({vecs[i].name, " fitness"}, out_fitness, vecs[i].exp_fit);
      check({vecs[i].name, " ovf"}, 64'(ovf), 64'(vecs[i].exp_ovf));
      release_out(vecs[i].name);
    end

    // Zero dimensions: straight to OUTPUT, no input handshake ever offered.
    do_start(0);
    check("zero out_valid", 64'(out_valid), 64'd1);
    check("zero fitness", out_fitness, 64'd0);
    check("zero ovf", 64'(ovf), 64'd0);
    check("zero in_ready", 64'(in_ready), 64'd0);
    release_out("zero");

    // Backpressure: result held, starts during OUTPUT and on the ack cycle ignored.
    do_start(1);
    send("bp", p(3, 0));
    for (int c = 0; c < 4; c++) begin
      check("bp out_valid hold", 64'(out_valid), 64'd1);
      check("bp fitness hold", out_fitness, 64'd3);
      start = (c == 1);
      ndim  = 8'd5;
      tick();
    end
    start = 1'b1;
    release_out("bp");
    start = 1'b0;
    tick();
    check("bp still idle", 64'(busy), 64'd0);

    // Input stall: idle-cycle product is discarded, gaps do not consume count.
    in_prod = big; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    do_start(2);
    send("stall", p(4, 0));
    for (int c = 0; c < 3; c++) begin
      check("stall in_ready", 64'(in_ready), 64'd1);
      check("stall out_valid", 64'(out_valid), 64'd0);
      tick();
    end
    send("stall", p(4, 0));
    check("stall out_valid", 64'(out_valid), 64'd1);
    check("stall fitness", out_fitness, 64'd4);
    check("stall ovf", 64'(ovf), 64'd0);
    release_out("stall");

    // Reset in the middle of ACCUM with a saturating product already folded in.
    do_start(4);
    send("rst", p(8, 0));
    send("rst", big);
    ap_rst = 1'b1; in_prod = p(50, 0); in_valid = 1'b1;
    tick();
    check("rst fitness", out_fitness, 64'd0);
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd0);
    check("rst busy", 64'(busy), 64'd0);
    check("rst ovf", 64'(ovf), 64'd0);
    ap_rst = 1'b0;
    tick();
    in_valid = 1'b0;
    check("rst needs start", 64'(busy), 64'd0);
    do_start(1);
    send("post_rst", p(1, 0));
    check("post_rst out_valid", 64'(out_valid), 64'd1);
    check("post_rst fitness", out_fitness, 64'd1);
    check("post_rst ovf", 64'(ovf), 64'd0);
    release_out("post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
